// File: rtl/downscale_pkg.sv
// downscale_pkg
// Shared types and default frame geometry for the bilinear downscaler and
// its stream output stage.
//   pixel_t         8-bit pixel
//   stream_state_t  output stage FSM states
//   DEF_DST_H/W     default destination frame size
//   idx_width()     counter width for an index range of n entries
package downscale_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CSUM   = 2'd2
    } stream_state_t;

    localparam int DEF_DST_H = 16;
    localparam int DEF_DST_W = 16;

    // A single-entry range still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/downscale_stream_out_raster_counter.sv
// raster_counter
// Row/column position counter that walks a DST_H x DST_W frame in raster
// order. Column wraps to 0 and bumps the row; the last position wraps to (0,0).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      force position to (0,0)
//   advance    step to the next raster position
//   row, col   current position
//   at_end     current position is (DST_H-1, DST_W-1)
module raster_counter
    import downscale_pkg::*;
#(
    parameter int DST_H = DEF_DST_H,
    parameter int DST_W = DEF_DST_W,
    localparam int RW = idx_width(DST_H),
    localparam int CW = idx_width(DST_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          at_end
);

    localparam logic [RW-1:0] ROW_MAX = RW'(DST_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(DST_W - 1);

    logic row_last;
    logic col_last;

    assign row_last = (row == ROW_MAX);
    assign col_last = (col == COL_MAX);
    assign at_end   = row_last & col_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/downscale_stream_out.sv
// downscale_stream_out
// Snapshots each new downscaler frame into a flop buffer and streams it out
// in raster order as a valid/ready byte stream, optionally followed by an
// 8-bit wrap-around checksum beat. The downscaler may start its next frame
// as soon as the snapshot is taken.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   frame_valid   downscaler done; a rising edge requests a capture
//   image_in      downscaler output frame, sampled on capture
//   m_valid       stream beat valid
//   m_ready       downstream accepts beat
//   m_data        pixel or checksum byte (registered)
//   m_last        final beat of the frame (registered)
//   busy          frame in flight, capture until final beat accepted
//   overrun       one-cycle pulse when a frame edge is dropped
//
// state  | meaning
// IDLE   | waiting for a frame edge, outputs low
// STREAM | presenting buffered pixels in raster order
// CSUM   | presenting the checksum beat
module downscale_stream_out
    import downscale_pkg::*;
#(
    parameter int DST_H       = DEF_DST_H,
    parameter int DST_W       = DEF_DST_W,
    parameter bit APPEND_CSUM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_valid,
    input  logic [7:0] image_in [0:DST_H-1][0:DST_W-1],
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       busy,
    output logic       overrun
);

    localparam int RW = idx_width(DST_H);
    localparam int CW = idx_width(DST_W);
    localparam logic [RW-1:0] ROW_MAX = RW'(DST_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(DST_W - 1);
    // Degenerate 1x1 frame without checksum: the first beat is also the last.
    localparam bit LAST_ON_FIRST = !APPEND_CSUM && (DST_H * DST_W == 1);

    stream_state_t state, state_nxt;

    pixel_t        frame_buf [0:DST_H-1][0:DST_W-1];
    pixel_t        csum;
    logic          fv_q;
    logic          cap;
    logic          capture;
    logic          xfer;
    logic          ctr_clear;
    logic          ctr_adv;
    logic          at_end;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] nxt_row;
    logic [CW-1:0] nxt_col;

    raster_counter #(
        .DST_H (DST_H),
        .DST_W (DST_W)
    ) u_raster_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .advance (ctr_adv),
        .row     (row),
        .col     (col),
        .at_end  (at_end)
    );

    assign cap     = frame_valid & ~fv_q;
    assign xfer    = m_valid & m_ready;
    assign m_valid = (state != IDLE);
    assign busy    = (state != IDLE);

    // m_data is registered, so the pixel after the one being accepted is
    // fetched one position ahead of the counter.
    assign nxt_col = (col == COL_MAX) ? '0 : col + 1'b1;
    assign nxt_row = (col == COL_MAX) ? row + 1'b1 : row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ctr_clear = 1'b0;
        ctr_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (cap) begin
                    capture   = 1'b1;
                    ctr_clear = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    ctr_adv = 1'b1;
                    if (at_end) begin
                        state_nxt = APPEND_CSUM ? CSUM : IDLE;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot buffer; contents are irrelevant until the next capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_buf <= image_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fv_q    <= 1'b0;
            overrun <= 1'b0;
            csum    <= '0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            fv_q    <= frame_valid;
            overrun <= cap & (state != IDLE);
            case (state)
                IDLE: begin
                    if (cap) begin
                        csum   <= '0;
                        m_data <= image_in[0][0];
                        m_last <= LAST_ON_FIRST;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        csum <= csum + m_data;
                        if (at_end) begin
                            // Checksum beat includes the pixel accepted now.
                            m_data <= APPEND_CSUM ? csum + m_data : '0;
                            m_last <= APPEND_CSUM;
                        end else begin
                            m_data <= frame_buf[nxt_row][nxt_col];
                            m_last <= !APPEND_CSUM && (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        m_data <= '0;
                        m_last <= 1'b0;
                    end
                end
                default: begin
                    m_data <= '0;
                    m_last <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/downscale_stream_out.md
# downscale_stream_out

Output stage placed directly after the sequential bilinear downscaler. On each new `done` from the downscaler it snapshots the DST_H×DST_W output frame into an internal buffer and streams it out in raster order (row 0 col 0 first) over a valid/ready byte stream. An optional trailing checksum beat is appended. The downscaler can start its next frame while the snapshot drains.

## Interface
Parameters:
- DST_H, 16, frame rows
- DST_W, 16, frame columns
- APPEND_CSUM, 1, when 1 append one checksum beat after the last pixel

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_valid  in  1  driven by downscaler `done`; rising edge marks a new frame
- image_in  in  [7:0] [0:DST_H-1][0:DST_W-1]  downscaler output frame, sampled on capture
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  8  pixel or checksum byte
- m_last  out  1  high on the final beat of the frame
- busy  out  1  high from capture until the final beat is accepted
- overrun  out  1  one-cycle pulse when a frame edge is dropped

## Operation
- Edge detect: register `frame_valid` into `fv_q`. Capture condition is `frame_valid & ~fv_q`. A level held high never re-triggers.
- State machine:
  - IDLE: outputs low. On the capture condition, copy the whole `image_in` into the buffer, clear row/col and the checksum, and go to STREAM.
  - STREAM: `m_valid`=1 and `m_data`=buf[row][col]. A beat transfers on `m_valid & m_ready`. On transfer, add the pixel to the checksum and advance col, wrapping to 0 and incrementing row.
    - After pixel (DST_H-1, DST_W-1) transfers: go to CSUM if APPEND_CSUM=1, else go to IDLE.
  - CSUM: `m_data` = sum of all pixels mod 256 (8-bit wrap-around accumulator). On transfer, go to IDLE.
- `m_last`: high on the final beat only. That is the CSUM beat when APPEND_CSUM=1, otherwise the last pixel beat.
- Beats per frame: DST_H·DST_W + APPEND_CSUM.
- A capture condition in STREAM or CSUM is ignored: the buffer is untouched and `overrun` pulses for one cycle.
- A capture condition in the same cycle the final beat transfers is also treated as overrun. The FSM returns to IDLE and does not re-arm.
- Reset mid-frame: return to IDLE immediately. The partial frame is abandoned with no `m_last`. Buffer contents are don't-care.

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, busy=0, overrun=0, fv_q=0, state=IDLE, row=col=0, checksum=0.
- Latency: capture edge at clock edge N gives `m_valid`=1 and the first pixel from N+1.
- Zero-bubble throughput: with `m_ready` held high, one beat per cycle. The frame finishes DST_H·DST_W+APPEND_CSUM cycles after `m_valid` rises. `busy` and `m_valid` fall on the cycle after the last transfer.
- Backpressure: while `m_valid & ~m_ready`, `m_data` and `m_last` hold stable. `m_valid` never drops before its transfer.
- `m_data`/`m_last` are registered outputs. Pixel read is from the flop buffer with no RAM read latency.
- `busy` is equal to (state != IDLE).

## Structure
- Shared package `downscale_pkg`:
  - `pixel_t` (logic [7:0])
  - `stream_state_t` enum {IDLE, STREAM, CSUM}
  - default DST_H/DST_W constants, also used by the downscaler
- One sub-module `raster_counter`:
  - parameterised row/col counter
  - inputs: clear, advance
  - outputs: row, col, `at_end` (row=DST_H-1 & col=DST_W-1)
  - wraps col→0 with row increment
- Buffer, checksum and FSM stay in the top module.

## Test plan
- Basic frame: image[r][c]=r·16+c, single `frame_valid` pulse, `m_ready`=1 → 257 beats with values 0,1,…,255, then checksum 128; `m_last` only on beat 257; first `m_valid` one cycle after the edge.
- Backpressure: same frame, `m_ready` toggled pseudo-randomly → identical byte sequence; `m_data` is stable on every stalled cycle; no beats lost or duplicated.
- Overrun: second `frame_valid` edge at beat 100 with image changed to all 0xFF → one `overrun` pulse; remaining output still follows the r·16+c pattern, checksum 128.
- Level hold: `frame_valid` held high for 600 cycles → exactly one frame streamed, `overrun`=0 throughout.
- Reset mid-frame: `rst` asserted at beat 50 → next cycle m_valid=0, busy=0, m_last never seen; new edge afterwards streams a complete frame from pixel (0,0).
- APPEND_CSUM=0, image all 0x7F → 256 beats of 0x7F, `m_last` on beat 256, busy low the following cycle.
